packet_rr_arbiter_if: RTL and testbench

// - Shares one if_axi_stream pipeline (e.g. a pipeline_bp stage feeding a multiplier core) between NUM_IN requesters.
// - Packet-aware round-robin: a grant is held from the sop beat through the eop beat, so packets never interleave.
// - Optionally tags ctl with the winning source index, so responses can be routed back downstream.

---
 rtl/packet_rr_arbiter_if_pkg.sv | 21 ++
 rtl/if_axi_stream.sv | 18 +
 rtl/packet_rr_arbiter_if_rr_select.sv | 15 +
 rtl/packet_rr_arbiter_if.sv | 188 ++++++++++++++++++
 tb/tb_packet_rr_arbiter_if.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_rr_arbiter_if_pkg.sv
// Shared types and the rotated-priority search used by the packet round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First requester after 'last' (wrapping within num), searched by increasing distance; up to 16 requesters.
    function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last, input int num);
        logic [3:0] k;
        rr_next = last;
        for (int i = 16; i >= 1; i--) begin
            k = 4'((int'(last) + i) % num);
            if ((i <= num) && req[k]) begin
                rr_next = k;
            end
        end
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Beat-oriented stream bundle: data plus packet framing, error, byte modulo and control sideband.
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BITS > 8) ? $clog2(DAT_BITS / 8) : 1
);
    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;
    logic                rdy;

    modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
    modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/packet_rr_arbiter_if_rr_select.sv
// Combinational round-robin picker: lowest-distance requester after 'last', with wrap.
module rr_select
    import arb_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int IDX_BITS = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0]   req,
    input  logic [IDX_BITS-1:0] last,
    output logic [IDX_BITS-1:0] idx,
    output logic                vld
);
    assign idx = IDX_BITS'(rr_next(16'(req), 4'(last), NUM_IN));
    assign vld = |req;
endmodule

// File: rtl/packet_rr_arbiter_if.sv
// Packet-aware round-robin arbiter: NUM_IN streams share one registered output stage.
// A grant is held from sop through eop so packets never interleave; ctl can carry the source index.
module packet_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter int TAG_CTL  = 1,
    parameter int IDX_BITS = $clog2(NUM_IN)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    if_axi_stream.sink          i_if [NUM_IN],
    if_axi_stream.source        o_if,
    output logic [IDX_BITS-1:0] o_grant,
    output logic                o_busy
);
    localparam int MOD_BITS = (DAT_BITS > 8) ? $clog2(DAT_BITS / 8) : 1;

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [IDX_BITS-1:0] grant_r;
    logic [IDX_BITS-1:0] grant_nxt_s;
    logic [IDX_BITS-1:0] sel_s;
    logic [IDX_BITS-1:0] rr_idx_s;
    logic                sel_vld_s;
    logic                rr_vld_s;
    logic                out_en_s;
    logic                xfer_s;
    logic                busy_r;

    logic [NUM_IN-1:0]   in_val_s;
    logic [NUM_IN-1:0]   in_sop_s;
    logic [NUM_IN-1:0]   in_eop_s;
    logic [NUM_IN-1:0]   in_err_s;
    logic [NUM_IN-1:0]   in_rdy_s;
    logic [NUM_IN-1:0]   req_s;
    logic [DAT_BITS-1:0] in_dat_s [NUM_IN];
    logic [MOD_BITS-1:0] in_mod_s [NUM_IN];
    logic [CTL_BITS-1:0] in_ctl_s [NUM_IN];
    logic [CTL_BITS-1:0] ctl_tag_s;

    logic                out_val_r;
    logic                out_sop_r;
    logic                out_eop_r;
    logic                out_err_r;
    logic [DAT_BITS-1:0] out_dat_r;
    logic [MOD_BITS-1:0] out_mod_r;
    logic [CTL_BITS-1:0] out_ctl_r;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign in_val_s[g] = i_if[g].val;
        assign in_sop_s[g] = i_if[g].sop;
        assign in_eop_s[g] = i_if[g].eop;
        assign in_err_s[g] = i_if[g].err;
        assign in_dat_s[g] = i_if[g].dat;
        assign in_mod_s[g] = i_if[g].mod;
        assign in_ctl_s[g] = i_if[g].ctl;
        assign i_if[g].rdy = in_rdy_s[g];
    end

    // Only packet starts compete for a fresh grant; stray mid-packet beats wait.
    assign req_s    = in_val_s & in_sop_s;
    assign out_en_s = ~out_val_r | o_if.rdy;

    rr_select #(
        .NUM_IN   (NUM_IN),
        .IDX_BITS (IDX_BITS)
    ) u_rr_select (
        .req  (req_s),
        .last (grant_r),
        .idx  (rr_idx_s),
        .vld  (rr_vld_s)
    );

    // Source selection and ready fan-out
    always_comb begin
        sel_s     = rr_idx_s;
        sel_vld_s = 1'b0;
        in_rdy_s  = {NUM_IN{1'b0}};
        case (state_r)
            LOCKED: begin
                sel_s     = grant_r;
                sel_vld_s = 1'b1;
            end
            IDLE: begin
                sel_s     = rr_idx_s;
                sel_vld_s = rr_vld_s;
            end
            default: begin
                sel_s     = rr_idx_s;
                sel_vld_s = 1'b0;
            end
        endcase
        if (out_en_s && sel_vld_s) begin
            in_rdy_s[sel_s] = 1'b1;
        end else begin
            in_rdy_s = {NUM_IN{1'b0}};
        end
    end

    assign xfer_s = out_en_s & sel_vld_s & in_val_s[sel_s];

    // Next-state and grant update
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    grant_nxt_s = sel_s;
                    state_nxt_s = in_eop_s[sel_s] ? IDLE : LOCKED;
                end else begin
                    grant_nxt_s = grant_r;
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && in_eop_s[sel_s]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    if (TAG_CTL != 0) begin : g_tag
        // Overwrite the low ctl bits with the winning source index
        always_comb begin
            ctl_tag_s                 = in_ctl_s[sel_s];
            ctl_tag_s[IDX_BITS-1:0]   = sel_s;
        end
    end else begin : g_notag
        assign ctl_tag_s = in_ctl_s[sel_s];
    end

    // Arbitration state, grant and busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            grant_r <= IDX_BITS'(NUM_IN - 1);
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            busy_r  <= (state_nxt_s == LOCKED);
        end
    end

    // Output stage: loads on a transfer, holds while stalled, empties otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_val_r <= 1'b0;
            out_sop_r <= 1'b0;
            out_eop_r <= 1'b0;
            out_err_r <= 1'b0;
            out_dat_r <= {DAT_BITS{1'b0}};
            out_mod_r <= {MOD_BITS{1'b0}};
            out_ctl_r <= {CTL_BITS{1'b0}};
        end else if (out_en_s) begin
            out_val_r <= xfer_s;
            if (xfer_s) begin
                out_sop_r <= in_sop_s[sel_s];
                out_eop_r <= in_eop_s[sel_s];
                out_err_r <= in_err_s[sel_s];
                out_dat_r <= in_dat_s[sel_s];
                out_mod_r <= in_mod_s[sel_s];
                out_ctl_r <= ctl_tag_s;
            end
        end
    end

    assign o_if.val = out_val_r;
    assign o_if.sop = out_sop_r;
    assign o_if.eop = out_eop_r;
    assign o_if.err = out_err_r;
    assign o_if.dat = out_dat_r;
    assign o_if.mod = out_mod_r;
    assign o_if.ctl = out_ctl_r;
    assign o_grant  = grant_r;
    assign o_busy   = busy_r;

endmodule

// File: tb/tb_packet_rr_arbiter_if.sv
// Self-checking bench for packet_rr_arbiter_if (NUM_IN=4, TAG_CTL=1): directed packet scenarios
// plus a randomized-stall run scored against per-source expected queues and round-robin rotation.
module tb_packet_rr_arbiter_if;

    typedef struct packed {
        logic [63:0] dat;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [7:0]  ctl;
        logic [7:0]  gap;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic [1:0]  src;
        logic [1:0]  grant;
        logic        busy;
        logic [31:0] cyc;
    } obs_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  drv_val;
    logic [3:0]  drv_sop;
    logic [3:0]  drv_eop;
    logic [3:0]  drv_err;
    logic [3:0]  mon_rdy;
    logic [63:0] drv_dat [4];
    logic [2:0]  drv_mod [4];
    logic [7:0]  drv_ctl [4];
    logic        drv_ordy;
    logic [1:0]  o_grant;
    logic        o_busy;

    if_axi_stream #(.DAT_BITS(64), .CTL_BITS(8)) in_if [4] ();
    if_axi_stream #(.DAT_BITS(64), .CTL_BITS(8)) out_if ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign in_if[g].val = drv_val[g];
        assign in_if[g].sop = drv_sop[g];
        assign in_if[g].eop = drv_eop[g];
        assign in_if[g].err = drv_err[g];
        assign in_if[g].dat = drv_dat[g];
        assign in_if[g].mod = drv_mod[g];
        assign in_if[g].ctl = drv_ctl[g];
        assign mon_rdy[g]   = in_if[g].rdy;
    end
    assign out_if.rdy = drv_ordy;

    packet_rr_arbiter_if #(
        .NUM_IN   (4),
        .DAT_BITS (64),
        .CTL_BITS (8),
        .TAG_CTL  (1)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_if    (in_if),
        .o_if    (out_if),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    beat_t        in_q  [4][$];
    beat_t        sb_q  [4][$];
    beat_t        exp_q [$];
    obs_t         out_log [$];
    int           gap_cnt [4];
    int           acc_sop_cyc [4];
    int           acc_eop_cyc [4];
    int           cyc = 0;
    bit           rand_rdy = 1'b0;
    bit           hold_chk = 1'b0;
    bit           busy_seen = 1'b0;
    logic [127:0] held;
    int           model_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pay(input beat_t b);
        return 128'({b.dat, b.sop, b.eop, b.err, b.mod, b.ctl});
    endfunction

    function automatic logic [127:0] out_snap();
        return 128'({out_if.val, out_if.dat, out_if.sop, out_if.eop, out_if.err, out_if.mod, out_if.ctl});
    endfunction

    function automatic beat_t mk_beat(input logic sop, input logic eop, input logic [7:0] gap);
        beat_t b;
        b.dat = {$urandom(), $urandom()};
        b.sop = sop;
        b.eop = eop;
        b.err = 1'($urandom_range(0, 1));
        b.mod = 3'($urandom_range(0, 7));
        b.ctl = 8'($urandom());
        b.gap = gap;
        return b;
    endfunction

    function automatic beat_t tag_beat(input beat_t b, input int s);
        beat_t t;
        t          = b;
        t.ctl[1:0] = 2'(s);
        t.gap      = 8'd0;
        return t;
    endfunction

    // One clock: present queue heads, sample at negedge, retire accepted beats, log output transfers.
    task automatic cycle();
        obs_t o;
        for (int k = 0; k < 4; k++) begin
            if (in_q[k].size() > 0 && gap_cnt[k] == 0) begin
                drv_val[k] = 1'b1;
                drv_sop[k] = in_q[k][0].sop;
                drv_eop[k] = in_q[k][0].eop;
                drv_err[k] = in_q[k][0].err;
                drv_dat[k] = in_q[k][0].dat;
                drv_mod[k] = in_q[k][0].mod;
                drv_ctl[k] = in_q[k][0].ctl;
            end else begin
                drv_val[k] = 1'b0;
            end
        end
        drv_ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge i_clk);
        if (hold_chk) chk("stall_hold", out_snap(), held);
        hold_chk = out_if.val && !drv_ordy;
        held     = out_snap();
        if (o_busy) busy_seen = 1'b1;
        if (out_if.val && drv_ordy) begin
            o.b     = '{dat: out_if.dat, sop: out_if.sop, eop: out_if.eop, err: out_if.err,
                        mod: out_if.mod, ctl: out_if.ctl, gap: 8'd0};
            o.src   = out_if.ctl[1:0];
            o.grant = o_grant;
            o.busy  = o_busy;
            o.cyc   = 32'(cyc);
            out_log.push_back(o);
        end
        for (int k = 0; k < 4; k++) begin
            if (drv_val[k] && mon_rdy[k]) begin
                if (drv_sop[k]) acc_sop_cyc[k] = cyc;
                if (drv_eop[k]) acc_eop_cyc[k] = cyc;
                void'(in_q[k].pop_front());
                gap_cnt[k] = (in_q[k].size() > 0) ? int'(in_q[k][0].gap) : 0;
            end else if (!drv_val[k] && gap_cnt[k] > 0) begin
                gap_cnt[k]--;
            end
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            gap_cnt[k] = (in_q[k].size() > 0) ? int'(in_q[k][0].gap) : 0;
        end
        while (out_log.size() < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 128'(out_log.size()), 128'(target));
    endtask

    initial begin
        i_rst_n  = 1'b0;
        drv_val  = 4'b0000;
        drv_sop  = 4'b0000;
        drv_eop  = 4'b0000;
        drv_err  = 4'b0000;
        drv_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv_dat[k] = 64'd0;
            drv_mod[k] = 3'd0;
            drv_ctl[k] = 8'd0;
            gap_cnt[k] = 0;
        end

        // Reset release with all inputs idle
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_val",   128'(out_if.val), 128'(1'b0));
        chk("rst_grant", 128'(o_grant),    128'(2'd3));
        chk("rst_busy",  128'(o_busy),     128'(1'b0));
        chk("rst_rdy",   128'(mon_rdy),    128'(4'b0000));
        @(posedge i_clk);
        #1;

        // Four simultaneous 3-beat packets: served 0,1,2,3 without interleaving
        exp_q.delete();
        out_log.delete();
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 3; j++) begin
                beat_t b;
                b = mk_beat(j == 0, j == 2, 8'd0);
                in_q[s].push_back(b);
                exp_q.push_back(tag_beat(b, s));
            end
        end
        run_until("t2_count", 12, 200);
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            chk("t2_beat",  pay(out_log[i].b),        pay(exp_q[i]));
            chk("t2_grant", 128'(out_log[i].grant),   128'(exp_q[i].ctl[1:0]));
            chk("t2_busy",  128'(out_log[i].busy),    128'(!exp_q[i].eop));
        end

        // Input 2 packet with 2-cycle val gaps while input 1 waits
        exp_q.delete();
        out_log.delete();
        for (int j = 0; j < 4; j++) begin
            beat_t b;
            b = mk_beat(j == 0, j == 3, (j == 0) ? 8'd0 : 8'd2);
            in_q[2].push_back(b);
            exp_q.push_back(tag_beat(b, 2));
        end
        for (int j = 0; j < 2; j++) begin
            beat_t b;
            b = mk_beat(j == 0, j == 1, (j == 0) ? 8'd2 : 8'd0);
            in_q[1].push_back(b);
            exp_q.push_back(tag_beat(b, 1));
        end
        run_until("t3_count", 6, 200);
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            chk("t3_beat",  pay(out_log[i].b),      pay(exp_q[i]));
            chk("t3_grant", 128'(out_log[i].grant), 128'(exp_q[i].ctl[1:0]));
            chk("t3_busy",  128'(out_log[i].busy),  128'(!exp_q[i].eop));
        end
        chk("t3_regrant_gap", 128'(acc_sop_cyc[1]), 128'(acc_eop_cyc[2] + 1));
        model_last = 1;

        // 1000 single-beat packets, all sources always pending, 50% output stall
        out_log.delete();
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 250; j++) begin
                beat_t b;
                b = mk_beat(1'b1, 1'b1, 8'd0);
                in_q[s].push_back(b);
                sb_q[s].push_back(tag_beat(b, s));
            end
        end
        rand_rdy = 1'b1;
        run_until("t4_count", 1000, 8000);
        rand_rdy = 1'b0;
        for (int i = 0; i < out_log.size(); i++) begin
            int s;
            int exp_src;
            exp_src = (model_last + 1) % 4;
            s       = int'(out_log[i].src);
            chk("t4_rr_order", 128'(s), 128'(exp_src));
            chk("t4_sb_avail", 128'(sb_q[s].size() > 0), 128'(1'b1));
            if (sb_q[s].size() > 0) chk("t4_sb_beat", pay(out_log[i].b), pay(sb_q[s].pop_front()));
            model_last = exp_src;
        end
        for (int s = 0; s < 4; s++) begin
            chk("t4_sb_left", 128'(sb_q[s].size()), 128'(0));
        end

        // Reset while locked on input 1
        out_log.delete();
        for (int j = 0; j < 4; j++) begin
            in_q[1].push_back(mk_beat(j == 0, j == 3, 8'd0));
        end
        cycle();
        cycle();
        chk("t5_locked", 128'(o_busy), 128'(1'b1));
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_val",   128'(out_if.val), 128'(1'b0));
        chk("t5_rst_busy",  128'(o_busy),     128'(1'b0));
        chk("t5_rst_grant", 128'(o_grant),    128'(2'd3));
        for (int k = 0; k < 4; k++) begin
            in_q[k].delete();
            gap_cnt[k] = 0;
        end
        drv_val  = 4'b0000;
        hold_chk = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("t5_rel_grant", 128'(o_grant),    128'(2'd3));
        chk("t5_rel_val",   128'(out_if.val), 128'(1'b0));
        @(posedge i_clk);
        #1;
        out_log.delete();
        exp_q.delete();
        begin
            beat_t b3;
            beat_t b0;
            b3 = mk_beat(1'b1, 1'b1, 8'd0);
            b0 = mk_beat(1'b1, 1'b1, 8'd0);
            in_q[3].push_back(b3);
            in_q[0].push_back(b0);
            exp_q.push_back(tag_beat(b0, 0));
            exp_q.push_back(tag_beat(b3, 3));
        end
        run_until("t5_count", 2, 50);
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            chk("t5_prio", pay(out_log[i].b), pay(exp_q[i]));
        end

        // Input 3 alone streaming single-beat packets at full rate
        out_log.delete();
        exp_q.delete();
        busy_seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            beat_t b;
            b = mk_beat(1'b1, 1'b1, 8'd0);
            in_q[3].push_back(b);
            exp_q.push_back(tag_beat(b, 3));
        end
        run_until("t6_count", 20, 100);
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            chk("t6_beat", pay(out_log[i].b), pay(exp_q[i]));
            if (i > 0) chk("t6_rate", 128'(out_log[i].cyc - out_log[i-1].cyc), 128'(32'd1));
        end
        cycle();
        chk("t6_never_busy", 128'(busy_seen), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
